// File: rtl/seg7_scan_marquee.sv
// Multiplexed common-anode seven-segment driver: buffered hex digits, refresh scan
// from a free-running prescaler, and optional marquee rotation of the message.
module seg7_scan_marquee #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 16,
  parameter int STEP_DIV   = 24,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*DIGITS-1:0]       digits_in,
  input  logic [DIGITS-1:0]         blank_in,
  input  logic                      en,
  input  logic                      mode,
  input  logic                      run,
  output logic [6:0]                seg,
  output logic [DIGITS-1:0]         anode,
  output logic [$clog2(DIGITS)-1:0] offset
);

  localparam int                IW      = $clog2(DIGITS);
  localparam logic [IW-1:0]     LAST    = IW'(DIGITS - 1);
  localparam logic [IW:0]       NDIG    = (IW + 1)'(DIGITS);
  localparam logic [6:0]        SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [SCAN_DIV-1:0] scan_cnt;
  logic [STEP_DIV-1:0] step_cnt;
  logic                scan_tick;
  logic                step_tick;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       off_q;
  logic [3:0]          nib_q [DIGITS];
  logic [DIGITS-1:0]   blank_q;
  logic [IW:0]         src_raw;
  logic [IW:0]         src_red;
  logic [IW-1:0]       src;
  logic [6:0]          seg_p0;
  logic [DIGITS-1:0]   anode_p0;
  logic [6:0]          seg_p1;
  logic [DIGITS-1:0]   anode_p1;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Explicit wrap keeps non-power-of-two digit counts legal.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (v == LAST) ? '0 : v + 1'b1;
  endfunction

  assign scan_tick = &scan_cnt;
  assign step_tick = &step_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      step_cnt <= '0;
      idx      <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      step_cnt <= step_cnt + 1'b1;
      if (scan_tick) idx <= wrap_inc(idx);
    end
  end

  // A load always restarts the message unrotated, even on a step tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) nib_q[i] <= 4'h0;
      blank_q <= '1;
      off_q   <= '0;
    end else begin
      if (load) begin
        for (int i = 0; i < DIGITS; i++) nib_q[i] <= digits_in[4*i +: 4];
        blank_q <= blank_in;
      end
      if (load || !mode)          off_q <= '0;
      else if (run && step_tick)  off_q <= wrap_inc(off_q);
    end
  end

  // Stage p0: pick the source digit for the current scan slot and decode it.
  always_comb begin
    src_raw  = {1'b0, idx} + {1'b0, off_q};
    src_red  = (src_raw >= NDIG) ? src_raw - NDIG : src_raw;
    src      = src_red[IW-1:0];
    seg_p0   = 7'h00;
    anode_p0 = '0;
    if (en) begin
      anode_p0[idx] = 1'b1;
      if (!blank_q[src]) seg_p0 = hex_to_seg(nib_q[src]);
    end
  end

  // Stage p1: registered pins; polarity is applied only here.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_p1   <= SEG_OFF;
      anode_p1 <= AN_OFF;
    end else begin
      seg_p1   <= (ACTIVE_LOW != 0) ? ~seg_p0   : seg_p0;
      anode_p1 <= (ACTIVE_LOW != 0) ? ~anode_p0 : anode_p0;
    end
  end

  assign seg    = seg_p1;
  assign anode  = anode_p1;
  assign offset = off_q;

endmodule

// File: tb/tb_seg7_scan_marquee.sv
// Bench for seg7_scan_marquee: cycle scoreboard on a 4-digit active-low instance,
// vector table for decode/scan slots, and a 3-digit active-high instance for wrap.
`timescale 1ns/1ps
module tb_seg7_scan_marquee;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst, load, en, mode, run;
  logic [15:0] digits_in;
  logic [3:0]  blank_in;
  logic [6:0]  seg;
  logic [3:0]  anode;
  logic [1:0]  offset;

  seg7_scan_marquee #(.DIGITS(4), .SCAN_DIV(2), .STEP_DIV(4), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .blank_in(blank_in),
    .en(en), .mode(mode), .run(run), .seg(seg), .anode(anode), .offset(offset)
  );

  logic        b_rst, b_load, b_en, b_mode, b_run;
  logic [11:0] b_digits;
  logic [2:0]  b_blank;
  logic [6:0]  b_seg;
  logic [2:0]  b_anode;
  logic [1:0]  b_offset;

  seg7_scan_marquee #(.DIGITS(3), .SCAN_DIV(2), .STEP_DIV(3), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst(b_rst), .load(b_load), .digits_in(b_digits), .blank_in(b_blank),
    .en(b_en), .mode(b_mode), .run(b_run), .seg(b_seg), .anode(b_anode), .offset(b_offset)
  );

  logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct packed { logic [6:0] seg; logic [3:0] an; logic [1:0] off; } exp_t;
  exp_t sbq [$];

  typedef struct { logic [15:0] dig; logic [3:0] blk; logic [3:0] an; logic [6:0] hi; } vec_t;
  vec_t vt [21];

  int          m_scan = 0, m_step = 0, m_idx = 0, m_off = 0;
  logic [15:0] m_dig  = '0;
  logic [3:0]  m_blank = 4'hF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference behaviour of the 4-digit instance for the edge about to happen.
  task automatic model_step(output exp_t e);
    int s;
    bit st_scan, st_step;
    if (rst) begin
      e.seg = 7'h7F; e.an = 4'hF;
      m_scan = 0; m_step = 0; m_idx = 0; m_off = 0; m_dig = '0; m_blank = 4'hF;
    end else begin
      s = (m_idx + m_off) % 4;
      if (!en) begin
        e.seg = 7'h7F; e.an = 4'hF;
      end else begin
        e.an = 4'hF;
        e.an[m_idx] = 1'b0;
        e.seg = m_blank[s] ? 7'h7F : ~dec_tab[m_dig[4*s +: 4]];
      end
      st_scan = (m_scan == 3);
      st_step = (m_step == 15);
      m_scan  = (m_scan + 1) % 4;
      m_step  = (m_step + 1) % 16;
      if (st_scan) m_idx = (m_idx + 1) % 4;
      if (load) begin m_dig = digits_in; m_blank = blank_in; m_off = 0; end
      else if (!mode) m_off = 0;
      else if (run && st_step) m_off = (m_off + 1) % 4;
    end
    e.off = 2'(m_off);
  endtask

  task automatic tick();
    exp_t e;
    logic [3:0] inv;
    model_step(e);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check("scoreboard", {seg, anode, offset}, {e.seg, e.an, e.off});
    inv = ~anode;
    check("onehot", ($countones(inv) <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_a(input logic [3:0] tgt, input string name);
    int n = 0;
    while (anode !== tgt && n < 40) begin tick(); n++; end
    if (anode !== tgt) begin
      total++; bad++;
      $display("FAIL %s timeout: anode=%b expected %b", name, anode, tgt);
    end
  endtask

  task automatic ticks_until_off(input logic [1:0] tgt, output int n);
    n = 0;
    while (offset !== tgt && n < 100) begin tick(); n++; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] a;
    logic [2:0] ab;
    logic [6:0] w;
    logic [3:0] nv;

    vt[0]  = '{16'h4321, 4'h0, 4'b1110, 7'h06};
    vt[1]  = '{16'h4321, 4'h0, 4'b1101, 7'h5B};
    vt[2]  = '{16'h4321, 4'h0, 4'b1011, 7'h4F};
    vt[3]  = '{16'h4321, 4'h0, 4'b0111, 7'h66};
    vt[4]  = '{16'h3210, 4'h0, 4'b1110, 7'h3F};
    vt[5]  = '{16'h3210, 4'h0, 4'b1101, 7'h06};
    vt[6]  = '{16'h3210, 4'h0, 4'b1011, 7'h5B};
    vt[7]  = '{16'h3210, 4'h0, 4'b0111, 7'h4F};
    vt[8]  = '{16'h7654, 4'h0, 4'b1110, 7'h66};
    vt[9]  = '{16'h7654, 4'h0, 4'b1101, 7'h6D};
    vt[10] = '{16'h7654, 4'h0, 4'b1011, 7'h7D};
    vt[11] = '{16'h7654, 4'h0, 4'b0111, 7'h07};
    vt[12] = '{16'hBA98, 4'h0, 4'b1110, 7'h7F};
    vt[13] = '{16'hBA98, 4'h0, 4'b1101, 7'h6F};
    vt[14] = '{16'hBA98, 4'h0, 4'b1011, 7'h77};
    vt[15] = '{16'hBA98, 4'h0, 4'b0111, 7'h7C};
    vt[16] = '{16'hFEDC, 4'h0, 4'b1110, 7'h39};
    vt[17] = '{16'hFEDC, 4'h0, 4'b1101, 7'h5E};
    vt[18] = '{16'hFEDC, 4'h0, 4'b1011, 7'h79};
    vt[19] = '{16'hFEDC, 4'h0, 4'b0111, 7'h71};
    vt[20] = '{16'h4321, 4'b0100, 4'b1011, 7'h00};

    rst = 1; load = 0; en = 1; mode = 0; run = 0; digits_in = '0; blank_in = '0;
    b_rst = 1; b_load = 0; b_en = 1; b_mode = 0; b_run = 0; b_digits = '0; b_blank = '0;

    repeat (3) tick();
    check("rst_seg", seg, 7'h7F);
    check("rst_anode", anode, 4'hF);
    check("rst_offset", offset, 2'd0);

    rst = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      a = 4'hF; a[k/4] = 1'b0;
      check("blank_scan_anode", anode, a);
      check("blank_scan_seg", seg, 7'h7F);
    end

    for (int i = 0; i < 21; i++) begin
      digits_in = vt[i].dig; blank_in = vt[i].blk; load = 1;
      tick();
      load = 0;
      tick();
      wait_a(vt[i].an, $sformatf("vec%0d_wait", i));
      w = ~vt[i].hi;
      check($sformatf("vec%0d_seg", i), seg, w);
    end

    digits_in = 16'h4321; blank_in = '0; mode = 1; run = 1; load = 1;
    tick();
    load = 0;
    ticks_until_off(2'd1, n);
    check("mq_reach1", offset, 2'd1);
    ticks_until_off(2'd2, n); check("mq_period_1to2", n, 16);
    ticks_until_off(2'd3, n); check("mq_period_2to3", n, 16);
    ticks_until_off(2'd0, n); check("mq_period_3to0", n, 16);
    ticks_until_off(2'd1, n); check("mq_period_0to1", n, 16);
    run = 0;
    tick();
    wait_a(4'b1110, "mq_an0_wait");
    w = ~7'h5B; check("mq_off1_an0", seg, w);
    wait_a(4'b0111, "mq_an3_wait");
    w = ~7'h06; check("mq_off1_an3", seg, w);
    repeat (64) tick();
    check("mq_frozen", offset, 2'd1);
    mode = 0;
    tick();
    check("mode_snap", offset, 2'd0);

    mode = 1; run = 1;
    ticks_until_off(2'd2, n);
    check("lw_reach2", offset, 2'd2);
    repeat (15) tick();
    digits_in = 16'h8765; load = 1;
    tick();
    load = 0;
    check("load_wins", offset, 2'd0);
    repeat (20) tick();

    mode = 0; digits_in = 16'h4321; blank_in = 4'b0100; load = 1;
    tick();
    load = 0;
    tick();
    wait_a(4'b1011, "blank_wait");
    check("blank_slot_seg", seg, 7'h7F);
    en = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("en_off_anode", anode, 4'hF);
      check("en_off_seg", seg, 7'h7F);
    end
    en = 1;
    repeat (12) tick();

    mode = 1; run = 1; blank_in = '0; load = 1;
    tick();
    load = 0;
    repeat (23) tick();
    rst = 1;
    tick();
    check("midrst_seg", seg, 7'h7F);
    check("midrst_anode", anode, 4'hF);
    check("midrst_offset", offset, 2'd0);
    rst = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      a = 4'hF; a[k/4] = 1'b0;
      check("post_rst_anode", anode, a);
      check("post_rst_seg", seg, 7'h7F);
    end

    check("b_rst_seg", b_seg, 7'h00);
    check("b_rst_anode", b_anode, 3'b000);
    check("b_rst_offset", b_offset, 2'd0);
    b_rst = 0; b_digits = 12'h210; b_blank = '0; b_load = 1;
    for (int k = 0; k < 16; k++) begin
      tick();
      b_load = 0;
      ab = 3'b000; ab[(k/4)%3] = 1'b1;
      check("b_scan_anode", b_anode, ab);
      w = (k == 0) ? 7'h00 : dec_tab[(k/4)%3];
      check("b_scan_seg", b_seg, w);
    end

    b_mode = 1; b_run = 1;
    n = 0;
    while (b_offset !== 2'd2 && n < 100) begin tick(); n++; end
    check("b_reach2", b_offset, 2'd2);
    n = 0;
    while (b_offset === 2'd2 && n < 100) begin tick(); n++; end
    check("b_wrap_to0", b_offset, 2'd0);
    check("b_step_period", n, 8);

    b_mode = 0;
    for (int v = 0; v < 16; v++) begin
      nv = 4'(v);
      b_digits = {nv, nv, nv}; b_load = 1;
      tick();
      b_load = 0;
      tick();
      check($sformatf("b_hex%0d", v), b_seg, dec_tab[v]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_marquee.md
Name: seg7_scan_marquee

Overview:
Parametrised multiplexed seven-segment driver for a DIGITS-wide common-anode display. It refreshes every digit in turn from an internal digit buffer loaded with hex nibbles and per-digit blank flags. An optional marquee mode rotates the message one position per step tick; the step tick comes from an internal prescaler, so no divided clock is generated. It sits between user logic and the board display pins and supersedes the fixed 4-digit sequencer.

Parameters:
DIGITS, 4, number of digits/anodes; legal range 2..8
SCAN_DIV, 16, refresh prescaler width; scan_tick period = 2^SCAN_DIV clk cycles
STEP_DIV, 24, marquee prescaler width; step_tick period = 2^STEP_DIV clk cycles
ACTIVE_LOW, 1, 1 = segments and anodes asserted low; 0 = asserted high

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  synchronous, active-high reset
load  input  1  1-cycle strobe; latches digits_in/blank_in into the buffer
digits_in  input  4*DIGITS  hex nibble per digit; digit i = [4i+3:4i], digit 0 rightmost
blank_in  input  DIGITS  1 = digit i dark
en  input  1  0 = all anodes off; scanning continues
mode  input  1  0 = static, 1 = marquee rotate
run  input  1  marquee advance enable; 0 freezes rotation
seg  output  7  {g,f,e,d,c,b,a}; bit0 = a
anode  output  DIGITS  one-hot digit select (polarity per ACTIVE_LOW)
offset  output  clog2(DIGITS)  current rotation offset (active-high binary)

Behaviour:
- All state updates on posedge clk. rst has priority over every other input.
- Reset: both prescalers = 0, scan index idx = 0, offset = 0, buffer = all nibbles 0 with all blank flags 1. seg = all segments off and anode = all digits off (7'h7F / all ones when ACTIVE_LOW=1; 0 otherwise).
- Prescalers are free-running up counters that wrap. scan_tick = 1 for the single cycle in which the scan counter is all ones. step_tick is generated the same way from the step counter.
- idx: on scan_tick, idx becomes idx==DIGITS-1 ? 0 : idx+1. Wrap is explicit, so non-power-of-2 DIGITS is supported.
- Buffer: when load=1, buffer takes digits_in/blank_in and offset is cleared to 0 in the same cycle. A load that coincides with step_tick clears offset; the load wins.
- offset:
  - mode=0: offset is forced to 0 every cycle.
  - mode=1, run=1, step_tick=1: offset becomes offset==DIGITS-1 ? 0 : offset+1.
  - mode=1, run=0: offset holds.
- Digit select: src = (idx + offset) mod DIGITS, computed in clog2(DIGITS)+1 bits with a conditional subtract of DIGITS.
- Outputs are registered, with 1-cycle latency from idx/offset/buffer/en to seg/anode.
  - en=1 and buffer[src] not blank: anode asserts bit idx only; seg = decode(nibble).
  - Blank digit: its anode still asserts, seg = all off.
  - en=0: anode = all off, seg = all off.
- Decode table, active-high gfedcba: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. ACTIVE_LOW=1 inverts seg and anode at the output register only.
- Simultaneous scan_tick and step_tick: both updates apply in the same cycle. The next output uses the new idx and the new offset.
- Mid-operation mode switch 1->0: offset is 0 on the next cycle; the display snaps to the unrotated message.
- Mid-operation rst: the next cycle reaches the full reset state; no partial frame is emitted afterwards.
- anode is never multi-hot in any cycle, including the cycles around reset and load.

Test Plan:
- Params DIGITS=4, SCAN_DIV=2, STEP_DIV=4, ACTIVE_LOW=1. Assert rst 3 cycles -> seg=7'h7F, anode=4'hF, offset=0. Release, no load -> anode cycles 1110,1101,1011,0111 every 4 clk with seg=7'h7F throughout (all blank).
- load digits_in=16'h4321, blank_in=0, mode=0 -> anode 1110 shows seg=~7'h06 ('1'); 1101 shows ~7'h5B; 1011 shows ~7'h4F; 0111 shows ~7'h66. Pattern repeats; each anode is held 4 clk.
- Same data, mode=1, run=1 -> offset steps 0,1,2,3,0 every 16 clk. With offset=1, anode 1110 shows '2' and 0111 shows '1'. Drop run -> offset frozen for ≥64 clk.
- blank_in=4'b0100, en toggled 1->0->1 -> digit 2 slot shows seg=7'h7F with anode 1011 asserted. en=0 cycles give anode=4'hF and seg=7'h7F, with idx still advancing (checked after en returns).
- load asserted in the cycle that step_tick fires with offset=2 -> offset=0 next cycle. rst asserted mid-frame -> full reset values next cycle, and anode is never multi-hot.
- DIGITS=3, STEP_DIV=3: idx wraps 0,1,2,0 and offset wraps 2->0. All hex values 0..F loaded across successive loads -> seg matches the decode table; ACTIVE_LOW=0 run gives the uninverted values.
